spi_master_frame: RTL and testbench

// - SPI mode-0 master issuing the 40-bit register frames served by our FPGA-side spi_slave.
// - Used for FPGA-to-FPGA links and as the bench-side initiator for the slave.
// - Frame, MSB first: header byte {wr, 3'b000, addr[3:0]}, then 32-bit data word.
// - Write (wr=1): slave stores data at addr. Read (wr=0): the last 32 MISO bits become rdata.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sclk_gen.sv | 31 +++
 rtl/spi_master_frame.sv | 121 ++++++++++++
 tb/tb_spi_master_frame.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared frame layout, FSM state encoding and header helper for the SPI frame master.
// Latency: none (package only).
// Backpressure: none (package only).
package spi_pkg;

  localparam int FRAME_BITS = 40;
  localparam int HDR_BITS   = 8;
  localparam int DATA_BITS  = FRAME_BITS - HDR_BITS;
  localparam int WR_BIT     = 7;
  localparam int ADDR_MSB   = 3;

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} spim_state_t;

  // Header byte: {wr, 3'b000, addr[3:0]}
  function automatic logic [HDR_BITS-1:0] make_hdr(input logic wr, input logic [ADDR_MSB:0] addr);
    logic [HDR_BITS-1:0] hdr;
    hdr              = '0;
    hdr[WR_BIT]      = wr;
    hdr[ADDR_MSB:0]  = addr;
    return hdr;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK phase timer: counts CLK_DIV clk cycles per SCLK half-period and flags the last one.
// Latency: phase_end is combinational from the counter; first tick CLK_DIV cycles after en rises.
// Backpressure: none; counter is held at 0 whenever en is low.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic phase_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Free-running phase counter while a frame is active, wrapping at CLK_DIV-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!en || div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign phase_end = en && (div_cnt == LAST);

endmodule

// File: rtl/spi_master_frame.sv
// SPI mode-0 master sending one 40-bit {hdr, data} frame per accepted start, capturing MISO.
// Latency: done pulses 83*CLK_DIV+1 clk cycles after the accept cycle.
// Backpressure: start is ignored while busy (through the done cycle); no queueing.
module spi_master_frame
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        SPI_CLK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  spim_state_t state;

  // Holds the bits still to be sent after the one currently on MOSI, MSB next.
  logic [FRAME_BITS-2:0] tx_sr;
  // Only the data bits are kept; header-period MISO bits shift out of the top.
  logic [DATA_BITS-1:0]  rx_sr;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-1:0] load_frame;
  logic                  phase_end;
  logic                  run;
  logic                  accept;

  assign load_frame = {make_hdr(wr, addr), (wr ? wdata : 32'h0)};
  assign accept     = (state == IDLE) && start && !busy;
  assign run        = (state != IDLE);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (run),
    .phase_end (phase_end)
  );

  // Frame sequencer: CS/SCLK/MOSI generation, MISO capture and done/busy handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      SPI_CLK  <= 1'b0;
      SPI_CS   <= 1'b1;
      SPI_MOSI <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays high through the done cycle, so a start there is dropped
          busy <= 1'b0;
          if (accept) begin
            tx_sr    <= load_frame[FRAME_BITS-2:0];
            rx_sr    <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            SPI_CS   <= 1'b0;
            SPI_MOSI <= load_frame[FRAME_BITS-1];
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end) state <= LOW;
        end
        LOW: begin
          if (phase_end) begin
            SPI_CLK <= 1'b1;
            rx_sr   <= {rx_sr[DATA_BITS-2:0], SPI_MISO};
            bit_cnt <= bit_cnt + 6'd1;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end) begin
            SPI_CLK <= 1'b0;
            if (bit_cnt == 6'(FRAME_BITS)) begin
              state <= HOLD;
            end else begin
              SPI_MOSI <= tx_sr[FRAME_BITS-2];
              tx_sr    <= {tx_sr[FRAME_BITS-3:0], 1'b0};
              state    <= LOW;
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            SPI_CS   <= 1'b1;
            SPI_MOSI <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: begin
          // CS-high gap lets the slave see the frame boundary before the next start
          if (phase_end) begin
            done  <= 1'b1;
            rdata <= rx_sr;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_frame.sv
// Self-checking bench: behavioural SPI slave + register model, random and directed frames.
// Latency: checks done arrives 83*CLK_DIV+1 cycles after accept.
// Backpressure: exercises start-while-busy, back-to-back starts and reset mid-frame.
module tb_spi_master_frame;

  localparam int D   = 4;
  localparam int LAT = 83 * D + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        wr;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        SPI_CLK;
  logic        SPI_CS;
  logic        SPI_MOSI;
  logic        SPI_MISO;

  always #5 clk = ~clk;

  spi_master_frame #(.CLK_DIV(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .SPI_CLK  (SPI_CLK),
    .SPI_CS   (SPI_CS),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- behavioural SPI slave (mode 0) ----------------
  logic [31:0] slv_regs  [16];
  logic [31:0] mem_model [16];
  logic [39:0] s_rx;
  logic [31:0] s_tx;
  int          s_bits;
  int          sclk_rises;
  logic [39:0] frames_q [$];

  initial SPI_MISO = 1'b0;

  always @(negedge SPI_CS) begin
    s_bits   = 0;
    s_rx     = '0;
    SPI_MISO = 1'($urandom);
  end

  always @(posedge SPI_CLK) begin
    if (SPI_CS === 1'b0) begin
      s_rx = {s_rx[38:0], SPI_MOSI};
      s_bits++;
      sclk_rises++;
    end
  end

  always @(negedge SPI_CLK) begin
    if (SPI_CS === 1'b0 && s_bits < 40) begin
      if (s_bits < 8) begin
        SPI_MISO = 1'($urandom);
      end else begin
        if (s_bits == 8) s_tx = s_rx[7] ? 32'($urandom) : slv_regs[s_rx[3:0]];
        SPI_MISO = s_tx[39 - s_bits];
      end
    end
  end

  always @(posedge SPI_CS) begin
    if (s_bits == 40) begin
      frames_q.push_back(s_rx);
      if (s_rx[39]) slv_regs[s_rx[35:32]] = s_rx[31:0];
    end
  end

  // ---------------- line monitor ----------------
  int   cs_low_cyc  = 0;
  int   cs_high_run = 0;
  int   last_gap    = 0;
  int   done_cnt    = 0;
  int   mosi_viol   = 0;
  logic prev_sclk   = 1'b0;
  logic prev_mosi   = 1'b0;

  always @(negedge clk) begin
    if (SPI_CS === 1'b0) begin
      cs_low_cyc++;
      if (cs_high_run > 0) last_gap = cs_high_run;
      cs_high_run = 0;
    end else begin
      cs_high_run++;
    end
    if (done === 1'b1) done_cnt++;
    if (SPI_CLK === 1'b1 && prev_sclk === 1'b1 && SPI_MOSI !== prev_mosi) mosi_viol++;
    prev_sclk = SPI_CLK;
    prev_mosi = SPI_MOSI;
  end

  // ---------------- one frame, fully checked ----------------
  task automatic run_frame(input logic f_wr, input logic [3:0] f_addr, input logic [31:0] f_wdata,
                           input int glitch_at, input string tag);
    int          cyc;
    int          d0;
    int          q0;
    logic [39:0] exp_frame;
    exp_frame = {f_wr, 3'b000, f_addr, (f_wr ? f_wdata : 32'h0)};
    @(negedge clk);
    #1;
    cs_low_cyc = 0; sclk_rises = 0; mosi_viol = 0;
    d0 = done_cnt; q0 = frames_q.size();
    start = 1'b1; wr = f_wr; addr = f_addr; wdata = f_wdata;
    @(negedge clk);
    start = 1'b0; wr = 1'($urandom); addr = 4'($urandom); wdata = $urandom;
    cyc = 1;
    chk({tag, " busy after accept"}, busy, 1'b1);
    chk({tag, " cs after accept"}, SPI_CS, 1'b0);
    chk({tag, " first mosi"}, SPI_MOSI, f_wr);
    while (done !== 1'b1 && cyc < 2000) begin
      if (glitch_at > 0 && cyc == glitch_at) begin
        start = 1'b1; wr = ~f_wr; addr = f_addr + 4'd1; wdata = ~f_wdata;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, " latency"}, cyc, LAT);
    if (!f_wr) chk({tag, " rdata"}, rdata, mem_model[f_addr]);
    else mem_model[f_addr] = f_wdata;
    repeat (20) @(negedge clk);
    #1;
    chk({tag, " done pulses"}, done_cnt - d0, 1);
    chk({tag, " frames seen"}, frames_q.size() - q0, 1);
    if (frames_q.size() > q0) chk({tag, " mosi frame"}, frames_q.pop_back(), exp_frame);
    chk({tag, " sclk rises"}, sclk_rises, 40);
    chk({tag, " cs low cycles"}, cs_low_cyc, 82 * D);
    chk({tag, " mosi stable"}, mosi_viol, 0);
    chk({tag, " idle after"}, {busy, SPI_CS}, 2'b01);
  endtask

  // ---------------- start held high: back-to-back frames ----------------
  task automatic back_to_back();
    int cyc;
    @(negedge clk);
    start = 1'b1; wr = 1'b0; addr = 4'd0; wdata = $urandom;
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      cyc = 1;
      chk("b2b accepted busy", busy, 1'b1);
      chk("b2b accepted cs", SPI_CS, 1'b0);
      #1;
      if (f > 0) chk("b2b cs gap >= CLK_DIV", (last_gap >= D), 1'b1);
      while (done !== 1'b1 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      chk("b2b latency", cyc, LAT);
      chk("b2b rdata", rdata, mem_model[0]);
      @(negedge clk);
      chk("b2b busy low after done", busy, 1'b0);
      chk("b2b cs high after done", SPI_CS, 1'b1);
      if (f == 2) start = 1'b0;
    end
    repeat (10) @(negedge clk);
    chk("b2b no extra frame", {busy, SPI_CS}, 2'b01);
  endtask

  // ---------------- reset at bit 20 ----------------
  task automatic reset_mid_frame();
    int cyc;
    int d0;
    @(negedge clk);
    #1;
    sclk_rises = 0;
    start = 1'b1; wr = 1'b0; addr = 4'd0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (sclk_rises < 20 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst reached bit 20", sclk_rises, 20);
    chk("rst rdata nonzero before", (rdata != 32'h0), 1'b1);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("rst cs", SPI_CS, 1'b1);
    chk("rst sclk", SPI_CLK, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst rdata", rdata, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 20) @(negedge clk);
    #1;
    chk("rst no done", done_cnt - d0, 0);
  endtask

  initial begin
    logic [3:0]  ra;
    logic [31:0] rd;
    logic        rw;
    reset = 1'b1; start = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem_model[i] = $urandom;
      slv_regs[i]  = mem_model[i];
    end
    mem_model[0] = 32'hDEADBEEF;
    slv_regs[0]  = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    chk("reset cs", SPI_CS, 1'b1);
    chk("reset sclk", SPI_CLK, 1'b0);
    chk("reset mosi", SPI_MOSI, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset rdata", rdata, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(1'b1, 4'd1, 32'h12345678, 0, "wr1");
    run_frame(1'b1, 4'd2, $urandom, 0, "wr2");
    run_frame(1'b0, 4'd1, $urandom, 0, "rd1");
    run_frame(1'b0, 4'd0, $urandom, 0, "rd0");
    run_frame(1'b1, 4'hA, 32'hA5A50F0F, 0, "wrA");
    run_frame(1'b0, 4'd3, 32'h0, 10, "glitch");

    for (int n = 0; n < 8; n++) begin
      rw = 1'($urandom);
      ra = 4'($urandom);
      rd = $urandom;
      run_frame(rw, ra, rd, 0, "rand");
    end

    back_to_back();
    reset_mid_frame();
    run_frame(1'b0, 4'd0, $urandom, 0, "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
